frame_tick_gen: RTL

Parametrised frame-rate tick generator, successor to the fixed-period frame counter. Divides `clk` into a frame pulse of runtime-programmable period, and derives `NUM_CH` independent game-logic tick channels (tank movement, bullet movement, animation) by dividing the frame pulse. Runtime-loadable period and dividers, a running frame count, and an optional game-pause freeze of the logic channels. Sits between the clock source and the game/renderer FSMs, which consume single-cycle pulses.

---
 rtl/frame_tick_pkg.sv | 18 +
 rtl/frame_tick_div.sv | 45 ++++
 rtl/frame_tick_gen.sv | 101 ++++++++++
 3 files changed

// File: rtl/frame_tick_pkg.sv
// Shared constants and types for the frame-rate tick generator.
// Holds the default parameter values and the channel-index width.
package frame_tick_pkg;

   localparam int DEF_PERIOD_W   = 16;
   localparam int DEF_PERIOD     = 49;
   localparam int DEF_NUM_CH     = 4;
   localparam int DEF_DIV_W      = 8;
   localparam int DEF_DIV        = 1;
   localparam int DEF_FCNT_W     = 16;

   // div_ch is always 4 bits wide, so at most 16 channels can be addressed.
   localparam int CH_IDX_W       = 4;
   localparam int MAX_NUM_CH     = 16;

   typedef logic [CH_IDX_W-1:0] ch_idx_t;

endpackage

// File: rtl/frame_tick_div.sv
// One game-logic tick channel: divides frame wraps by a loadable divider.
// A divider of zero disables the channel and freezes its counter.
module frame_tick_div
   import frame_tick_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = DEF_DIV
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             i_adv,
   input  logic             i_ld,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_ccnt;
   logic             r_tick;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_div  <= DIV_W'(DEFAULT_DIV);
         r_ccnt <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         // A load restarts the channel phase and swallows a coincident wrap.
         if (i_ld) begin
            r_div  <= i_div;
            r_ccnt <= '0;
         end else if (i_adv && (r_div != '0)) begin
            if (r_ccnt == r_div - 1'b1) begin
               r_ccnt <= '0;
               r_tick <= 1'b1;
            end else begin
               r_ccnt <= r_ccnt + 1'b1;
            end
         end
      end
   end

   assign o_tick = r_tick;

endmodule

// File: rtl/frame_tick_gen.sv
// Frame-rate tick generator with NUM_CH divided game-logic tick channels.
// Optional macro FRAME_TICK_PAUSE_EN lets `pause` freeze the channels only.
module frame_tick_gen
   import frame_tick_pkg::*;
#(
   parameter int PERIOD_W       = DEF_PERIOD_W,
   parameter int DEFAULT_PERIOD = DEF_PERIOD,
   parameter int NUM_CH         = DEF_NUM_CH,
   parameter int DIV_W          = DEF_DIV_W,
   parameter int DEFAULT_DIV    = DEF_DIV,
   parameter int FCNT_W         = DEF_FCNT_W
) (
   input  logic                clk,
   input  logic                RST,
   input  logic                en,
   input  logic                pause,
   input  logic                period_ld,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic                div_ld,
   input  logic [CH_IDX_W-1:0] div_ch,
   input  logic [DIV_W-1:0]    div_in,
   output logic                frame_tick,
   output logic [NUM_CH-1:0]   ch_tick,
   output logic [FCNT_W-1:0]   frame_cnt
);

   logic [PERIOD_W-1:0] r_cnt;
   logic [PERIOD_W-1:0] r_period;
   logic                r_frame_tick;
   logic [FCNT_W-1:0]   r_frame_cnt;

   logic [PERIOD_W-1:0] w_period_eff;
   logic                w_last;
   logic                w_wrap;
   logic                w_pause;
   logic                w_ch_adv;
   logic [NUM_CH-1:0]   w_ld;

   // Periods 0 and 1 both mean "tick every enabled cycle".
   assign w_period_eff = (r_period == '0) ? PERIOD_W'(1) : r_period;
   assign w_last       = (r_cnt == w_period_eff - 1'b1);
   assign w_wrap       = en && w_last && !period_ld;

`ifdef FRAME_TICK_PAUSE_EN
   assign w_pause = pause;
`else
   logic w_unused_pause;
   assign w_unused_pause = pause;
   assign w_pause        = 1'b0;
`endif

   assign w_ch_adv = w_wrap && !w_pause;

   always_ff @(posedge clk) begin
      if (RST) begin
         r_cnt        <= '0;
         r_period     <= PERIOD_W'(DEFAULT_PERIOD);
         r_frame_tick <= 1'b0;
         r_frame_cnt  <= '0;
      end else begin
         // NOTE: a period load restarts the frame and so outranks a coincident wrap.
         if (period_ld) begin
            r_period     <= period_in;
            r_cnt        <= '0;
            r_frame_tick <= 1'b0;
         end else if (en) begin
            if (w_last) begin
               r_cnt        <= '0;
               r_frame_tick <= 1'b1;
               r_frame_cnt  <= r_frame_cnt + 1'b1;
            end else begin
               r_cnt        <= r_cnt + 1'b1;
               r_frame_tick <= 1'b0;
            end
         end else begin
            r_frame_tick <= 1'b0;
         end
      end
   end

   // Out-of-range div_ch values never match any channel, so those loads vanish.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_ld[g] = div_ld && (div_ch == CH_IDX_W'(g));

      frame_tick_div #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_div (
         .clk    (clk),
         .RST    (RST),
         .i_adv  (w_ch_adv),
         .i_ld   (w_ld[g]),
         .i_div  (div_in),
         .o_tick (ch_tick[g])
      );
   end

   assign frame_tick = r_frame_tick;
   assign frame_cnt  = r_frame_cnt;

endmodule
